// File: rtl/pipe_chain_pkg.sv
// pipe_chain_pkg: shared widths, the bubble payload and the slot-action
// encoding used by the pipeline-register chain.
//   REG_BUS      default payload width per slot
//   PIPE_CNT_BUS default width of the performance counters
//   BUBBLE_BIT   fill value for a bubble payload (all bits take this value)
//   slot_op_e    what a slot does at the next edge
package pipe_chain_pkg;

  localparam int REG_BUS      = 32;
  localparam int PIPE_CNT_BUS = 16;
  localparam logic BUBBLE_BIT = 1'b0;

  typedef enum logic [1:0] {
    SLOT_LOAD   = 2'd0,
    SLOT_BUBBLE = 2'd1,
    SLOT_HOLD   = 2'd2,
    SLOT_KILL   = 2'd3
  } slot_op_e;

  // Priority: kill beats hold, hold beats bubble, otherwise load.
  function automatic slot_op_e slot_op(input logic flush_hit, input logic hold,
                                       input logic bubble);
    if (flush_hit)   return SLOT_KILL;
    else if (hold)   return SLOT_HOLD;
    else if (bubble) return SLOT_BUBBLE;
    else             return SLOT_LOAD;
  endfunction

  // Flush indices past the last slot behave as "flush everything".
  function automatic int clamp_upto(input int upto, input int stages);
    return (upto >= stages) ? stages - 1 : upto;
  endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// pipe_chain_if: fetch/control side and slot-output side of the chain.
//   master: drives in_valid/in_data, stall_req, flush, flush_upto;
//           observes in_ready, stg_valid, stg_data, stall_cnt, flush_cnt
//   slave : the chain itself (directions reversed)
// W/STAGES/CNT_W must match the parameters of the pipe_chain it connects to.
interface pipe_chain_if
  import pipe_chain_pkg::*;
#(
  parameter int W      = REG_BUS,
  parameter int STAGES = 4,
  parameter int CNT_W  = PIPE_CNT_BUS
) ();

  localparam int FW = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic                  in_valid;
  logic [W-1:0]          in_data;
  logic                  in_ready;
  logic [STAGES-1:0]     stall_req;
  logic                  flush;
  logic [FW-1:0]         flush_upto;
  logic [STAGES-1:0]     stg_valid;
  logic [STAGES*W-1:0]   stg_data;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output in_valid, in_data, stall_req, flush, flush_upto,
    input  in_ready, stg_valid, stg_data, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_data, stall_req, flush, flush_upto,
    output in_ready, stg_valid, stg_data, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_chain_slot.sv
// pipe_slot: one valid+payload pipeline register.
//   clk, rst   clock and synchronous active-high reset
//   flush_hit  slot is inside the flushed range this cycle
//   hold       this slot or an older one is stalled
//   bubble     the next-younger slot is held, so nothing arrives here
//   d_valid/d_data  predecessor contents
//   q_valid/q_data  registered slot contents
module pipe_slot
  import pipe_chain_pkg::*;
#(
  parameter int W = REG_BUS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_hit,
  input  logic         hold,
  input  logic         bubble,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);

  slot_op_e op;

  always_comb begin
    op = slot_op(flush_hit, hold, bubble);
  end

  // A killed slot keeps its stale payload; only the valid bit is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else begin
      case (op)
        SLOT_KILL: begin
          q_valid <= 1'b0;
        end
        SLOT_HOLD: begin
          q_valid <= q_valid;
          q_data  <= q_data;
        end
        SLOT_BUBBLE: begin
          q_valid <= 1'b0;
          q_data  <= {W{BUBBLE_BIT}};
        end
        default: begin
          q_valid <= d_valid;
          q_data  <= d_data;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_chain.sv
// pipe_chain: STAGES-deep pipeline-register chain with per-slot stall,
// bubble insertion, partial flush, an input handshake and saturating
// stall/flush cycle counters.
//   clk, rst  clock and synchronous active-high reset
//   bus       pipe_chain_if slave: in_valid/in_data/in_ready handshake,
//             stall_req, flush, flush_upto, stg_valid, stg_data
//             (slot i at [i*W +: W]), stall_cnt, flush_cnt
// Slot 0 is youngest; slot STAGES-1 is the write-back output.
module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int W      = REG_BUS,
  parameter int STAGES = 4,
  parameter int CNT_W  = PIPE_CNT_BUS
) (
  input logic         clk,
  input logic         rst,
  pipe_chain_if.slave bus
);

  localparam int FW = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic [STAGES-1:0]        hold;
  logic [STAGES-1:0]        flush_hit;
  logic [STAGES-1:0]        slot_valid;
  logic [STAGES-1:0][W-1:0] slot_data;
  logic [FW-1:0]            upto_c;
  logic [CNT_W-1:0]         stall_cnt_q;
  logic [CNT_W-1:0]         flush_cnt_q;

  always_comb begin
    upto_c = FW'(clamp_upto(int'(bus.flush_upto), STAGES));
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    logic         d_valid;
    logic [W-1:0] d_data;
    logic         bubble;

    // A stall anywhere at or above slot i freezes slot i.
    assign hold[i]      = |bus.stall_req[STAGES-1:i];
    assign flush_hit[i] = bus.flush && (upto_c >= FW'(i));

    if (i == 0) begin : g_head
      assign d_valid = bus.in_valid;
      assign d_data  = bus.in_data;
      assign bubble  = 1'b0;
    end else begin : g_body
      assign d_valid = slot_valid[i-1];
      assign d_data  = slot_data[i-1];
      assign bubble  = hold[i-1];
    end

    pipe_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush_hit (flush_hit[i]),
      .hold      (hold[i]),
      .bubble    (bubble),
      .d_valid   (d_valid),
      .d_data    (d_data),
      .q_valid   (slot_valid[i]),
      .q_data    (slot_data[i])
    );
  end

  // During a flush slot 0 is always killed, so the input is taken and dropped.
  assign bus.in_ready  = !hold[0] || bus.flush;
  assign bus.stg_valid = slot_valid;
  assign bus.stg_data  = slot_data;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((|bus.stall_req) && !bus.flush && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (bus.flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: drives a 4-slot and a 3-slot chain with the same stimulus
// and compares both against a slot-level reference model every cycle.
// The 3-slot copy exercises flush_upto clamping (index 3 is out of range).
module tb_pipe_chain;

  localparam int W     = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        stim_valid;
  logic [31:0] stim_data;
  logic [3:0]  stim_stall;
  logic        stim_flush;
  logic [1:0]  stim_upto;

  int passed = 0;
  int total  = 0;

  // Reference model state: [dut][slot], dut 0 has 4 slots, dut 1 has 3.
  logic        mv [2][4];
  logic [31:0] md [2][4];
  int          msc[2];
  int          mfc[2];

  logic        r_s;
  logic        v_s;
  logic [31:0] d_s;
  logic [3:0]  st_s;
  logic        f_s;
  logic [1:0]  u_s;

  pipe_chain_if #(.W(W), .STAGES(4), .CNT_W(CNT_W)) bus4 ();
  pipe_chain_if #(.W(W), .STAGES(3), .CNT_W(CNT_W)) bus3 ();

  assign bus4.in_valid   = stim_valid;
  assign bus4.in_data    = stim_data;
  assign bus4.stall_req  = stim_stall;
  assign bus4.flush      = stim_flush;
  assign bus4.flush_upto = stim_upto;
  assign bus3.in_valid   = stim_valid;
  assign bus3.in_data    = stim_data;
  assign bus3.stall_req  = stim_stall[2:0];
  assign bus3.flush      = stim_flush;
  assign bus3.flush_upto = stim_upto;

  pipe_chain #(.W(W), .STAGES(4), .CNT_W(CNT_W)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  pipe_chain #(.W(W), .STAGES(3), .CNT_W(CNT_W)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  always #5 clk = ~clk;

  function automatic int nstg(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  // Highest stalled slot of a chain, or -1 when nothing is stalled.
  function automatic int top_stall(input int d);
    int hi = -1;
    for (int i = 0; i < nstg(d); i++) if (stim_stall[i]) hi = i;
    return hi;
  endfunction

  // Compares one observed value with its expected value and counts it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      passed++;
    end
  endtask

  // Advances the model by one clock edge from the current stimulus:
  // everything up to the highest stalled slot freezes, the slot just above
  // it takes a bubble, the rest shift one place; flushed slots go invalid.
  task automatic modelEdge();
    logic        ov[4];
    logic [31:0] od[4];
    int n, hi, lim;
    for (int d = 0; d < 2; d++) begin
      n = nstg(d);
      if (rst) begin
        for (int i = 0; i < 4; i++) begin mv[d][i] = 1'b0; md[d][i] = '0; end
        msc[d] = 0;
        mfc[d] = 0;
      end else begin
        hi  = top_stall(d);
        lim = -1;
        if (stim_flush) lim = (int'(stim_upto) > n - 1) ? n - 1 : int'(stim_upto);
        for (int i = 0; i < 4; i++) begin ov[i] = mv[d][i]; od[i] = md[d][i]; end
        for (int i = 0; i < n; i++) begin
          if (i <= lim) begin
            mv[d][i] = 1'b0;
          end else if (i <= hi) begin
            mv[d][i] = ov[i];
          end else if (hi >= 0 && i == hi + 1) begin
            mv[d][i] = 1'b0;
            md[d][i] = '0;
          end else if (i == 0) begin
            mv[d][i] = stim_valid;
            md[d][i] = stim_data;
          end else begin
            mv[d][i] = ov[i-1];
            md[d][i] = od[i-1];
          end
        end
        if (hi >= 0 && !stim_flush && msc[d] < CMAX) msc[d]++;
        if (stim_flush && mfc[d] < CMAX) mfc[d]++;
      end
    end
  endtask

  // Compares every slot and counter of both chains against the model.
  // Payloads are only compared where the model says the slot is valid.
  task automatic checkState();
    logic [3:0]   ov;
    logic [127:0] od;
    logic [3:0]   osc, ofc;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        ov = bus4.stg_valid; od = bus4.stg_data;
        osc = bus4.stall_cnt; ofc = bus4.flush_cnt;
      end else begin
        ov = {1'b0, bus3.stg_valid}; od = {32'b0, bus3.stg_data};
        osc = bus3.stall_cnt; ofc = bus3.flush_cnt;
      end
      for (int i = 0; i < nstg(d); i++) begin
        checkOutput($sformatf("d%0d_valid%0d", d, i), 32'(ov[i]), 32'(mv[d][i]));
        if (mv[d][i]) checkOutput($sformatf("d%0d_data%0d", d, i), od[i*32 +: 32], md[d][i]);
      end
      checkOutput($sformatf("d%0d_stall_cnt", d), 32'(osc), 32'(msc[d]));
      checkOutput($sformatf("d%0d_flush_cnt", d), 32'(ofc), 32'(mfc[d]));
    end
  endtask

  // Drives one cycle of stimulus, checks the combinational in_ready,
  // takes the edge and then checks the registered state.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] data,
                               input logic [3:0] stall, input logic f, input logic [1:0] upto);
    rst        = r;
    stim_valid = v;
    stim_data  = data;
    stim_stall = stall;
    stim_flush = f;
    stim_upto  = upto;
    #1;
    checkOutput("d0_in_ready", 32'(bus4.in_ready), 32'((top_stall(0) < 0) || f));
    checkOutput("d1_in_ready", 32'(bus3.in_ready), 32'((top_stall(1) < 0) || f));
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkState();
  endtask

  // Directed scenarios first, then a long randomized run with rare resets.
  initial begin
    rst = 1'b1;
    stim_valid = 1'b0; stim_data = '0; stim_stall = '0; stim_flush = 1'b0; stim_upto = '0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin mv[d][i] = 1'b0; md[d][i] = '0; end
      msc[d] = 0; mfc[d] = 0;
    end
    @(negedge clk);

    // Reset with a live input offered.
    applyStimulus(1'b1, 1'b1, 32'hA5, 4'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 32'hA5, 4'b0, 1'b0, 2'd0);
    checkOutput("rst_valid", 32'(bus4.stg_valid), 32'h0);
    checkOutput("rst_data3", bus4.stg_data[96 +: 32], 32'h0);
    checkOutput("rst_ready", 32'(bus4.in_ready), 32'h1);

    // Streaming 1..5.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b1, 32'(k), 4'b0, 1'b0, 2'd0);
      if (k == 4) checkOutput("stream_slot3_first", bus4.stg_data[96 +: 32], 32'd1);
    end
    checkOutput("stream_slot3_next", bus4.stg_data[96 +: 32], 32'd2);

    // Mid-chain stall on slot 1 for two cycles, then release.
    applyStimulus(1'b0, 1'b1, 32'd6, 4'b0010, 1'b0, 2'd0);
    checkOutput("stall_slot3_takes3", bus4.stg_data[96 +: 32], 32'd3);
    applyStimulus(1'b0, 1'b1, 32'd6, 4'b0010, 1'b0, 2'd0);
    checkOutput("stall_slot1_holds", bus4.stg_data[32 +: 32], 32'd4);
    checkOutput("stall_bubbles", 32'(bus4.stg_valid), 32'b0011);
    checkOutput("stall_cnt_two", 32'(bus4.stall_cnt), 32'd2);
    applyStimulus(1'b0, 1'b1, 32'd6, 4'b0000, 1'b0, 2'd0);
    checkOutput("release_slot2", bus4.stg_data[64 +: 32], 32'd4);

    // Flush of slots 0..1 while slot 1 is stalled.
    applyStimulus(1'b0, 1'b1, 32'd7, 4'b0010, 1'b1, 2'd1);
    checkOutput("flush_low_invalid", 32'(bus4.stg_valid[1:0]), 32'b00);
    checkOutput("flush_cnt_one", 32'(bus4.flush_cnt), 32'd1);

    // Fill, then flush everything; index 3 clamps on the 3-slot chain.
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 32'(8 + k), 4'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 32'd12, 4'b0, 1'b1, 2'd3);
    checkOutput("full_flush_d0", 32'(bus4.stg_valid), 32'h0);
    checkOutput("full_flush_d1_clamp", 32'(bus3.stg_valid), 32'h0);

    // Reset during a stall and flush.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 32'(20 + k), 4'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 32'd30, 4'b0100, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 32'd31, 4'b0100, 1'b1, 2'd0);
    checkOutput("mid_stall_rst_valid", 32'(bus4.stg_valid), 32'h0);
    checkOutput("mid_stall_rst_cnt", 32'(bus4.stall_cnt), 32'h0);

    // Saturating stall counter.
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b1, 32'(40 + k), 4'b0001, 1'b0, 2'd0);
    checkOutput("stall_cnt_sat", 32'(bus4.stall_cnt), 32'd15);

    // Randomized traffic.
    applyStimulus(1'b1, 1'b0, 32'd0, 4'b0, 1'b0, 2'd0);
    for (int k = 0; k < 400; k++) begin
      r_s  = ($urandom_range(63) == 0);
      v_s  = 1'($urandom_range(1));
      d_s  = $urandom;
      st_s = '0;
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) st_s[b] = 1'b1;
      f_s  = ($urandom_range(7) == 0);
      u_s  = 2'($urandom_range(3));
      applyStimulus(r_s, v_s, d_s, st_s, f_s, u_s);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised pipeline-register chain with stall and flush control. It replaces the fixed, hand-wired if_id / id_ex / ex_mem / mem_wb register modules with STAGES generic slots. Each slot carries a valid bit and a W-bit payload. The chain adds per-stage stall requests with bubble insertion, a partial flush, an input handshake and saturating stall/flush counters, none of which the current fixed pipeline has. The core top instantiates it between the fetch output and write-back, with stage logic reading the slot outputs.

## Interface
- W, default 32: payload width per slot (instruction, PC and control fields packed by the core).
- STAGES, default 4: number of register slots. Must be ≥2.
- CNT_W, default 16: width of each performance counter.
- FW: derived localparam, $clog2(STAGES) (minimum 1).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch offers a payload.
- in_data  in  W  fetch payload.
- in_ready  out  1  payload accepted this cycle (combinational).
- stall_req  in  STAGES  bit i: the consumer of slot i cannot accept it this cycle.
- flush  in  1  kill younger stages.
- flush_upto  in  FW  highest slot index killed. Values ≥ STAGES are clamped to STAGES-1.
- stg_valid  out  STAGES  valid bit of each slot.
- stg_data  out  STAGES*W  slot i occupies bits [i*W +: W].
- stall_cnt  out  CNT_W  cycles with any stall active (saturating).
- flush_cnt  out  CNT_W  cycles with flush asserted (saturating).

## Operation
- Slot 0 is youngest and loads from in_data/in_valid. Slot i loads from slot i-1. Slot STAGES-1 is the write-back output.
- hold[i] = OR of stall_req[STAGES-1:i].
- Per slot i, evaluated each cycle in priority order:
  1. If flush and i ≤ flush_upto: valid ← 0; data is don't-care (implementation holds it).
  2. Else if hold[i]: slot keeps both valid and data.
  3. Else if i>0 and hold[i-1]: the slot receives a bubble (valid ← 0, data ← 0).
  4. Else: load from the predecessor. For slot 0, the predecessor is in_valid/in_data.
- in_ready = !hold[0] | flush. During a flush, input is consumed and discarded, not written.
- A stall on slot i freezes slots 0..i, inserts a bubble into slot i+1, and lets older slots drain.
- Invalid slots still obey stall and hold, so there is no bubble collapsing.
- stall_cnt increments when |stall_req && !flush, and saturates at all-ones.
- flush_cnt increments when flush is asserted, and saturates.
- Reset (sync, wins over everything, including mid-stall and mid-flush): all stg_valid=0, stg_data=0, stall_cnt=0, flush_cnt=0. in_ready then follows its combinational equation.

## Timing
- A payload accepted at edge k appears in slot j after edge k+j (0-based slot index). With no stalls it is visible at the output slot STAGES-1 after edge k+STAGES-1, i.e. STAGES cycles from acceptance to leaving the chain.
- Throughput is one payload per cycle when there are no stalls.
- All outputs are registered except in_ready.
- stall_req and flush are sampled at the same edge. Flush has priority only for slots ≤ flush_upto. Older slots still honour stalls.
- Simultaneous stall_req bits: the highest set index governs hold. A bubble is inserted only above the highest stalled slot.
- Counters update at the same edge as the event and are visible the following cycle.

## Structure
- Shared defines header: default W (`RegBus`), a `PipeCntBus` width macro, and a `Bubble` payload constant (0).
- Sub-module pipe_slot: one valid+data register implementing the priority rules above, with inputs flush_hit, hold, bubble, d_valid, d_data.
- pipe_chain instantiates pipe_slot STAGES times in a generate loop, plus the hold OR-chain and the two counters.

## Test plan
1. **Reset.** Assert rst for 2 cycles with in_valid=1, in_data=0xA5. All stg_valid=0, stg_data=0, both counters 0, in_ready=1.
2. **Streaming** (STAGES=4). Push 1,2,3,4,5 on consecutive cycles. Slot 3 shows 1 after the 4th edge, then 2,3,4,5 on consecutive cycles, with in_ready=1 throughout.
3. **Mid-chain stall.**
   - Setup: slots 0..3 = 5,4,3,2; stall_req=4'b0010 for 2 cycles.
   - Expected: slots 0/1 hold 5/4. Slot 2 gets a bubble. Slot 3 takes 3, then a bubble. in_ready=0; stall_cnt=2.
   - After release: 4 advances on the next edge.
4. **Flush beats stall.** flush=1, flush_upto=1, stall_req=4'b0010, in_valid=1. Slots 0/1 become invalid, slots 2/3 behave per the stall rules, the input is dropped, in_ready=1, flush_cnt=1.
5. **Full flush with clamp.** Flush with flush_upto=3 (or an out-of-range value when STAGES=3). Every slot is invalid after one edge. Reset asserted mid-stall clears everything.
6. **Counter saturation.** With CNT_W=4, hold stall_req[0] for 20 cycles. stall_cnt stays at 15 and does not wrap.
